cpu_run_ctrl: RTL

Parametrised run-control sequencer for the BatPU2 core. It owns the start/halt/enable logic that gates the program counter and the control-unit output lines. On top of plain start/halt it adds single-step mode, N address breakpoints, configurable memory wait states, and cycle/instruction counters. It sits between the external debug/start pins, the control unit and the datapath, and drives the datapath's `pc_en`, `pc_sync_rst` and the control-line gate.

---
 rtl/run_ctrl_pkg.sv | 20 ++
 rtl/cpu_run_ctrl_bp_match.sv | 19 +
 rtl/cpu_run_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state/cause encodings for the run-control sequencer
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_PAUSED  = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HLT  = 2'd1,
    CAUSE_EXT  = 2'd2,
    CAUSE_BP   = 2'd3
  } halt_cause_t;

  localparam int MEM_WAIT_MAX = 15;

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// rtl/cpu_run_ctrl_bp_match.sv - OR of NUM_BP enabled address comparators against the fetch PC
module bp_match #(
  parameter int IADDR_W = 10,
  parameter int NUM_BP  = 2
) (
  input  logic [IADDR_W-1:0]        pc,
  input  logic [NUM_BP-1:0]         bp_en,
  input  logic [NUM_BP*IADDR_W-1:0] bp_addr,
  output logic                      hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[i*IADDR_W +: IADDR_W] == pc)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - start/halt/step/breakpoint sequencer gating PC advance and control lines
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int IADDR_W  = 10,
  parameter int NUM_BP   = 2,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      halt_req,
  input  logic                      step_mode,
  input  logic                      step_req,
  input  logic [IADDR_W-1:0]        pc,
  input  logic                      hlt_inst,
  input  logic                      mem_access,
  input  logic [NUM_BP-1:0]         bp_en,
  input  logic [NUM_BP*IADDR_W-1:0] bp_addr,
  output logic                      pc_en,
  output logic                      ctrl_en,
  output logic                      pc_sync_rst,
  output logic [1:0]                run_state,
  output logic [1:0]                halt_cause,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instr_cnt
);

  localparam int          WAIT_LOAD_I = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;
  localparam logic [3:0]  WAIT_LOAD   = WAIT_LOAD_I[3:0];

  run_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic        skip_q, skip_d;
  logic [3:0]  wait_q, wait_d;
  logic        clear_cnt;
  logic        bp_hit;

  bp_match #(.IADDR_W(IADDR_W), .NUM_BP(NUM_BP)) u_bp_match (
    .pc      (pc),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .hit     (bp_hit)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    skip_d      = skip_q;
    wait_d      = wait_q;
    pc_en       = 1'b0;
    ctrl_en     = 1'b0;
    pc_sync_rst = 1'b0;
    clear_cnt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cause_d   = CAUSE_NONE;
          skip_d    = 1'b1;
          clear_cnt = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          pc_sync_rst = 1'b1;
          state_d     = ST_IDLE;
          cause_d     = CAUSE_EXT;
        end else if (hlt_inst) begin
          // HLT itself retires so it sees its own control lines
          pc_en       = 1'b1;
          ctrl_en     = 1'b1;
          pc_sync_rst = 1'b1;
          state_d     = ST_IDLE;
          cause_d     = CAUSE_HLT;
        end else if (bp_hit && !skip_q) begin
          state_d = ST_PAUSED;
          cause_d = CAUSE_BP;
        end else if (mem_access && (MEM_WAIT > 0)) begin
          wait_d  = WAIT_LOAD;
          state_d = ST_MEMWAIT;
        end else begin
          pc_en   = 1'b1;
          ctrl_en = 1'b1;
          skip_d  = 1'b0;
          if (step_mode) begin
            state_d = ST_PAUSED;
            cause_d = CAUSE_NONE;
          end
        end
      end
      ST_MEMWAIT: begin
        if (halt_req) begin
          pc_sync_rst = 1'b1;
          state_d     = ST_IDLE;
          cause_d     = CAUSE_EXT;
        end else if (wait_q == 4'd0) begin
          pc_en   = 1'b1;
          ctrl_en = 1'b1;
          skip_d  = 1'b0;
          if (step_mode) begin
            state_d = ST_PAUSED;
            cause_d = CAUSE_NONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_PAUSED: begin
        if (halt_req) begin
          pc_sync_rst = 1'b1;
          state_d     = ST_IDLE;
          cause_d     = CAUSE_EXT;
        end else if (start || step_req) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      skip_q    <= 1'b0;
      wait_q    <= 4'd0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      skip_q  <= skip_d;
      wait_q  <= wait_d;
      if (clear_cnt) begin
        cycle_cnt <= '0;
        instr_cnt <= '0;
      end else begin
        if ((state_q == ST_RUN) || (state_q == ST_MEMWAIT)) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (pc_en && ctrl_en) instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  assign run_state  = state_q;
  assign halt_cause = cause_q;

endmodule
